// File: rtl/digit_serial_mult_ctrl.sv
// Digit-serial unsigned WIDTH x WIDTH multiplier built around one shared
// 2x2 multiplier, stepping one digit pair per cycle into an accumulator.
// Ports:
//   clk, rst            clock, async active-high reset
//   in_valid/in_ready   operand handshake (a, b unsigned WIDTH bits)
//   out_valid/out_ready product handshake (product unsigned 2*WIDTH bits)

module two_bit_multiplier (
   input  logic [1:0] x,
   input  logic [1:0] y,
   output logic [3:0] p
);
   assign p = {2'b00, x} * {2'b00, y};
endmodule

module digit_serial_mult_ctrl #(
   parameter int WIDTH = 12
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] product
);
   localparam int N  = WIDTH / 2;
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam int PW = 2 * WIDTH;
   localparam int SW = $clog2(PW) + 1;
   localparam logic [IW-1:0] LAST = IW'(N - 1);

   typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

   state_t          state;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [IW-1:0]   i;
   logic [IW-1:0]   j;
   logic [PW-1:0]   acc;
   logic [PW-1:0]   pp_ext;
   logic [PW-1:0]   acc_nxt;
   logic [1:0]      a_dig;
   logic [1:0]      b_dig;
   logic [3:0]      pp;
   logic [SW-1:0]   sh;

   // Digit i of a and digit j of b, selected by shifting right 2 bits/digit.
   assign a_dig = 2'(a_q >> {i, 1'b0});
   assign b_dig = 2'(b_q >> {j, 1'b0});

   two_bit_multiplier u_mul (
      .x (a_dig),
      .y (b_dig),
      .p (pp)
   );

   // Partial product weight is 4^(i+j).
   assign sh      = SW'({i, 1'b0}) + SW'({j, 1'b0});
   assign pp_ext  = PW'(pp) << sh;
   assign acc_nxt = acc + pp_ext;

   assign in_ready = (state == IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         a_q       <= '0;
         b_q       <= '0;
         i         <= '0;
         j         <= '0;
         acc       <= '0;
         out_valid <= 1'b0;
         product   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  a_q   <= a;
                  b_q   <= b;
                  acc   <= '0;
                  i     <= '0;
                  j     <= '0;
                  state <= MUL;
               end
            end
            MUL: begin
               acc <= acc_nxt;
               if (j == LAST) begin
                  j <= '0;
                  if (i == LAST) begin
                     product   <= acc_nxt;
                     out_valid <= 1'b1;
                     state     <= DONE;
                  end else begin
                     i <= i + 1'b1;
                  end
               end else begin
                  j <= j + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_digit_serial_mult_ctrl.sv
// Randomized self-checking bench for digit_serial_mult_ctrl against a
// transaction-level model (a*b after N*N cycles, handshake timing).

module tb_digit_serial_mult_ctrl;
   localparam int W   = 12;
   localparam int NN  = (W / 2) * (W / 2);

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          out_valid;
   logic          out_ready;
   logic [2*W-1:0] product;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   digit_serial_mult_ctrl #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [63:0] act,
                        input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Transaction-level model: busy for NN cycles after accept, then
   // presents a*b until the output handshake.
   logic          m_ready = 1'b1;
   logic          m_valid = 1'b0;
   logic [2*W-1:0] m_prod = '0;
   logic [2*W-1:0] m_pend = '0;
   int            m_left = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_ready = 1'b1;
         m_valid = 1'b0;
         m_prod  = '0;
         m_left  = 0;
      end else if (m_ready && in_valid) begin
         m_ready = 1'b0;
         m_left  = NN;
         m_pend  = {12'b0, a} * {12'b0, b};
      end else if (m_left > 0) begin
         m_left--;
         if (m_left == 0) begin
            m_valid = 1'b1;
            m_prod  = m_pend;
         end
      end else if (m_valid && out_ready) begin
         m_valid = 1'b0;
         m_ready = 1'b1;
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         check("cyc_in_ready", in_ready, m_ready);
         check("cyc_out_valid", out_valid, m_valid);
         check("cyc_product", product, m_prod);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic accept(input logic [W-1:0] ta, input logic [W-1:0] tb);
      int k;
      k = 0;
      while (!in_ready && k < 200) begin
         tick();
         k++;
      end
      check("accept_ready", in_ready, 1);
      a        = ta;
      b        = tb;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      a        = W'($urandom);
      b        = W'($urandom);
      check("accept_drop", in_ready, 0);
   endtask

   task automatic wait_out(output int n);
      n = 0;
      while (!out_valid && n < 200) begin
         tick();
         n++;
      end
   endtask

   task automatic run(input logic [W-1:0] ta, input logic [W-1:0] tb,
                      input logic [2*W-1:0] exp, input string nm);
      int n;
      out_ready = 1'b1;
      accept(ta, tb);
      wait_out(n);
      check({nm, "_latency"}, n, NN);
      check({nm, "_product"}, product, exp);
      tick();
      check({nm, "_ready_back"}, in_ready, 1);
      check({nm, "_valid_low"}, out_valid, 0);
   endtask

   task automatic backpressure();
      int n;
      out_ready = 1'b0;
      accept(W'(17), W'(200));
      wait_out(n);
      check("bp_latency", n, NN);
      in_valid = 1'b1;
      a        = W'(5);
      b        = W'(5);
      for (int k = 0; k < 20; k++) begin
         tick();
         check("bp_valid_hold", out_valid, 1);
         check("bp_product_hold", product, 3400);
         check("bp_no_accept", in_ready, 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      check("bp_valid_drop", out_valid, 0);
      check("bp_ready_back", in_ready, 1);
      check("bp_product_keep", product, 3400);
      tick();
      check("bp_single_hs", out_valid, 0);
   endtask

   task automatic mid_reset();
      out_ready = 1'b1;
      accept(W'(1234), W'(999));
      repeat (10) tick();
      #2 rst = 1'b1;
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_product", product, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_in_ready", in_ready, 1);
      repeat (45) tick();
      check("rst_no_stale", out_valid, 0);
      run(W'(2), W'(3), 24'd6, "after_rst");
   endtask

   task automatic back_to_back();
      logic [2*W-1:0] q[$];
      logic [2*W-1:0] e;
      logic           take;
      int             n_acc;
      int             n_out;
      int             last;
      n_acc     = 0;
      n_out     = 0;
      last      = -1;
      out_ready = 1'b1;
      a         = W'($urandom);
      b         = W'($urandom);
      in_valid  = 1'b1;
      for (int k = 0; k < 6000 && n_out < 100; k++) begin
         take = in_ready && in_valid;
         if (take) q.push_back({12'b0, a} * {12'b0, b});
         tick();
         if (take) begin
            n_acc++;
            if (n_acc == 100) in_valid = 1'b0;
            a = W'($urandom);
            b = W'($urandom);
         end
         if (out_valid) begin
            n_out++;
            e = (q.size() > 0) ? q.pop_front() : 'x;
            check("b2b_product", product, e);
            if (last >= 0) check("b2b_spacing", cyc - last, NN + 2);
            last = cyc;
         end
      end
      in_valid = 1'b0;
      check("b2b_count", n_out, 100);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a         = '0;
      b         = '0;
      repeat (3) tick();
      rst = 1'b0;
      #1;
      check("reset_in_ready", in_ready, 1);
      check("reset_out_valid", out_valid, 0);
      check("reset_product", product, 0);

      run(W'(3328), W'(3328), 24'd11075584, "sq3328");
      run(W'(4095), W'(4095), 24'd16769025, "ones");
      run(W'(0), W'(2731), 24'd0, "zero");
      backpressure();
      mid_reset();
      back_to_back();
      run(W'(100), W'(300), 24'd30000, "opchg");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
